// File: rtl/ex_mul_sequencer.sv
// Multi-cycle shift-add multiplier for MUL in the EX stage: one multiplier bit
// per cycle, WIDTH RUN cycles then one DONE cycle that presents the product.
// Ports: clk/rst_n (sync active-low), mul_EX/flush_EX (start/squash),
//   op_a_EX/op_b_EX (operands), stall_mul (pipeline freeze),
//   mul_done/mul_product (one-cycle product strobe, product held until next DONE).
module ex_mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mul_EX,
  input  logic             flush_EX,
  input  logic [WIDTH-1:0] op_a_EX,
  input  logic [WIDTH-1:0] op_b_EX,
  output logic             stall_mul,
  output logic             mul_done,
  output logic [WIDTH-1:0] mul_product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  logic             start;
  logic             last_iter;
  logic [WIDTH-1:0] acc_next;

  // A flush in the same cycle as mul_EX squashes the MUL before it starts.
  assign start     = mul_EX & ~flush_EX;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  // Carry out of the accumulator is dropped: only the low WIDTH bits matter,
  // which also makes the result correct for two's-complement operands.
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;

  // Low in DONE so the MUL leaves EX on the DONE edge.
  assign stall_mul = ((state == IDLE) & start) | (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      mul_done    <= 1'b0;
      mul_product <= '0;
    end else begin
      mul_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= op_a_EX;
            mplier <= op_b_EX;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush_EX) begin
            // Abandon the operation; mul_product keeps its previous value.
            state <= IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_iter) begin
              // Capture the accumulator including the final iteration's add.
              mul_product <= acc_next;
              mul_done    <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          // mul_EX is still high for the instruction leaving EX; ignore it.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mul_sequencer.sv
module tb_ex_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mul_EX = 1'b0;
  logic        flush_EX = 1'b0;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic        stall_mul;
  logic        mul_done;
  logic [63:0] mul_product;

  int passed = 0;
  int total  = 0;

  int          stalls;
  int          n_done;
  int          done_cyc0;
  int          done_cyc1;
  logic [63:0] prod0;
  logic [63:0] prod1;
  logic        probe_stall;
  logic        probe_done;
  logic [63:0] probe_prod;

  ex_mul_sequencer #(.WIDTH(64), .CNT_W(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mul_EX      (mul_EX),
    .flush_EX    (flush_EX),
    .op_a_EX     (op_a),
    .op_b_EX     (op_b),
    .stall_mul   (stall_mul),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one MUL (optionally a second back-to-back), with optional flush or
  // reset in cycle flush_at / rst_at. Cycle 0 is the IDLE cycle where mul_EX is
  // first seen. Operands are scrambled in cycle 5 to prove they are latched.
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] a2, input logic [63:0] b2,
                         input bit two, input int flush_at, input int rst_at,
                         input int ncyc);
    logic saw_done;
    stalls = 0; n_done = 0; done_cyc0 = -1; done_cyc1 = -1;
    prod0 = 'x; prod1 = 'x;
    probe_stall = 'x; probe_done = 'x; probe_prod = 'x;
    op_a = a; op_b = b; mul_EX = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (c == flush_at) flush_EX = 1'b1;
      if (c == rst_at) rst_n = 1'b0;
      if (c == 5) begin
        op_a = 64'hDEAD_BEEF_0123_4567;
        op_b = 64'h5555_AAAA_5555_AAAA;
      end
      #1;
      if (stall_mul) stalls++;
      if (c == flush_at + 1 || c == rst_at + 1) begin
        probe_stall = stall_mul;
        probe_done  = mul_done;
        probe_prod  = mul_product;
      end
      saw_done = mul_done;
      if (mul_done) begin
        if (n_done == 0) begin done_cyc0 = c; prod0 = mul_product; end
        else begin done_cyc1 = c; prod1 = mul_product; end
        n_done++;
      end
      @(posedge clk);
      #1;
      if (c == flush_at || c == rst_at) begin
        flush_EX = 1'b0; rst_n = 1'b1; mul_EX = 1'b0;
      end
      if (saw_done) begin
        if (two && n_done == 1) begin op_a = a2; op_b = b2; end
        else mul_EX = 1'b0;
      end
    end
  endtask

  initial begin
    // 1. Reset and idle
    step();
    rst_n = 1'b1;
    #1;
    check("rst_stall", 64'(stall_mul), 64'd0);
    check("rst_done", 64'(mul_done), 64'd0);
    check("rst_product", mul_product, 64'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      #1;
      check("idle_stall", 64'(stall_mul), 64'd0);
      check("idle_done", 64'(mul_done), 64'd0);
    end
    check("idle_product", mul_product, 64'd0);

    // 2. 7 * 6
    run_mul(64'd7, 64'd6, 64'd0, 64'd0, 1'b0, -10, -10, 80);
    check("t2_stall_cycles", 64'(stalls), 64'd65);
    check("t2_done_cycle", 64'(done_cyc0), 64'd65);
    check("t2_done_count", 64'(n_done), 64'd1);
    check("t2_product", prod0, 64'd42);
    #1;
    check("t2_stall_after", 64'(stall_mul), 64'd0);
    check("t2_product_hold", mul_product, 64'd42);

    // 3. Signed and wrap cases
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0, 64'd0, 1'b0, -10, -10, 70);
    check("t3_neg_product", prod0, 64'hFFFF_FFFF_FFFF_FFFD);
    check("t3_neg_done_cycle", 64'(done_cyc0), 64'd65);
    run_mul(64'h8000_0000_0000_0000, 64'd2, 64'd0, 64'd0, 1'b0, -10, -10, 70);
    check("t3_wrap_product", prod0, 64'd0);
    check("t3_wrap_done_count", 64'(n_done), 64'd1);

    // Restore 42 so the flush test can observe an unchanged product.
    run_mul(64'd7, 64'd6, 64'd0, 64'd0, 1'b0, -10, -10, 70);
    check("t3_reload_42", prod0, 64'd42);

    // 4. Flush at RUN cycle 20
    run_mul(64'd5, 64'd5, 64'd0, 64'd0, 1'b0, 20, -10, 90);
    check("t4_stall_after_flush", 64'(probe_stall), 64'd0);
    check("t4_stall_cycles", 64'(stalls), 64'd21);
    check("t4_done_count", 64'(n_done), 64'd0);
    check("t4_product_kept", mul_product, 64'd42);

    // 5. Back-to-back 3*4 then 10*10
    run_mul(64'd3, 64'd4, 64'd10, 64'd10, 1'b1, -10, -10, 145);
    check("t5_done_count", 64'(n_done), 64'd2);
    check("t5_first_product", prod0, 64'd12);
    check("t5_second_product", prod1, 64'd100);
    check("t5_first_done", 64'(done_cyc0), 64'd65);
    check("t5_pulse_gap", 64'(done_cyc1 - done_cyc0), 64'd66);
    check("t5_stall_cycles", 64'(stalls), 64'd130);

    // 6. Reset at RUN cycle 30, then 2*9
    run_mul(64'd11, 64'd13, 64'd0, 64'd0, 1'b0, -10, 30, 40);
    check("t6_stall_after_rst", 64'(probe_stall), 64'd0);
    check("t6_done_after_rst", 64'(probe_done), 64'd0);
    check("t6_product_after_rst", probe_prod, 64'd0);
    check("t6_done_count", 64'(n_done), 64'd0);
    run_mul(64'd2, 64'd9, 64'd0, 64'd0, 1'b0, -10, -10, 70);
    check("t6_product", prod0, 64'd18);
    check("t6_done_cycle", 64'(done_cyc0), 64'd65);
    check("t6_stall_cycles", 64'(stalls), 64'd65);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
